blk_nblk: RTL and testbench

// - Side-by-side register pair contrasting two capture disciplines on one input word.
// - BLK path: both outputs load the input on the same edge (out2 is a copy of out1, 1-cycle latency each).
// - NBLK path: true 2-stage shift register (out1 = 1-cycle delay, out2 = 2-cycle delay).
// - Used as a teaching/regression block for assignment-semantics checks in the lab suite.

---
 rtl/blk_nblk_pkg.sv | 11 +
 rtl/blk_nblk_reg.sv | 35 +++
 rtl/blk_nblk.sv | 79 +++++++
 tb/tb_blk_nblk.sv | 117 +++++++++++
 4 files changed

// File: rtl/blk_nblk_pkg.sv
// Shared constants for the blk_nblk register-pair block.
// - BLK_NBLK_WIDTH_DEFAULT : default data width of the block.
// - BLK_NBLK_RST_VAL       : reset value for any stage, sliced to the stage width.
package blk_nblk_pkg;

  localparam int BLK_NBLK_WIDTH_DEFAULT = 4;
  localparam int BLK_NBLK_WIDTH_MAX     = 32;

  localparam logic [BLK_NBLK_WIDTH_MAX-1:0] BLK_NBLK_RST_VAL = '0;

endpackage

// File: rtl/blk_nblk_reg.sv
// WIDTH-bit D flop with synchronous active-high reset to zero.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears q
//   d   : data captured every rising edge when rst is low
//   q   : registered data
module blk_nblk_reg
  import blk_nblk_pkg::*;
#(
  parameter int WIDTH = BLK_NBLK_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= BLK_NBLK_RST_VAL[WIDTH-1:0];
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/blk_nblk.sv
// Side-by-side register pair contrasting two capture disciplines on one word.
//   BLK path : both stages load `in` on the same edge, so blk_out2 always
//              equals blk_out1 (1-cycle latency each).
//   NBLK path: true 2-stage shift register (1-cycle and 2-cycle latency).
// Optional feature: define BLK_NBLK_MISMATCH_EN to add the `mismatch`
// output, high whenever blk_out2 differs from nblk_out2.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset, clears all four outputs
//   in        : data word sampled every rising edge
//   blk_out1  : BLK path stage 1
//   blk_out2  : BLK path stage 2
//   nblk_out1 : NBLK path stage 1
//   nblk_out2 : NBLK path stage 2
//   mismatch  : (BLK_NBLK_MISMATCH_EN only) blk_out2 != nblk_out2
module blk_nblk
  import blk_nblk_pkg::*;
#(
  parameter int WIDTH = BLK_NBLK_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] blk_out1,
  output logic [WIDTH-1:0] blk_out2,
  output logic [WIDTH-1:0] nblk_out1,
  output logic [WIDTH-1:0] nblk_out2
`ifdef BLK_NBLK_MISMATCH_EN
  ,
  output logic             mismatch
`endif
);

  logic [WIDTH-1:0] blk_a_p1;
  logic [WIDTH-1:0] blk_b_p1;
  logic [WIDTH-1:0] nblk_p1;
  logic [WIDTH-1:0] nblk_p2;

  // ---- stage p0 -> p1: BLK pair both fed from in; NBLK first stage ----
  blk_nblk_reg #(.WIDTH(WIDTH)) u_blk_s1 (
    .clk (clk),
    .rst (rst),
    .d   (in),
    .q   (blk_a_p1)
  );

  blk_nblk_reg #(.WIDTH(WIDTH)) u_blk_s2 (
    .clk (clk),
    .rst (rst),
    .d   (in),
    .q   (blk_b_p1)
  );

  blk_nblk_reg #(.WIDTH(WIDTH)) u_nblk_s1 (
    .clk (clk),
    .rst (rst),
    .d   (in),
    .q   (nblk_p1)
  );

  // ---- stage p1 -> p2: NBLK second stage takes the old first-stage value ----
  blk_nblk_reg #(.WIDTH(WIDTH)) u_nblk_s2 (
    .clk (clk),
    .rst (rst),
    .d   (nblk_p1),
    .q   (nblk_p2)
  );

  assign blk_out1  = blk_a_p1;
  assign blk_out2  = blk_b_p1;
  assign nblk_out1 = nblk_p1;
  assign nblk_out2 = nblk_p2;

`ifdef BLK_NBLK_MISMATCH_EN
  // Both compared flops clear together, so this is 0 after reset.
  assign mismatch = (blk_b_p1 != nblk_p2);
`endif

endmodule

// File: tb/tb_blk_nblk.sv
module tb_blk_nblk;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic [W-1:0] blk_out1;
  logic [W-1:0] blk_out2;
  logic [W-1:0] nblk_out1;
  logic [W-1:0] nblk_out2;
`ifdef BLK_NBLK_MISMATCH_EN
  logic         mismatch;
`endif

  int checks;
  int errors;

  blk_nblk #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (din),
    .blk_out1  (blk_out1),
    .blk_out2  (blk_out2),
    .nblk_out1 (nblk_out1),
    .nblk_out2 (nblk_out2)
`ifdef BLK_NBLK_MISMATCH_EN
    ,
    .mismatch  (mismatch)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Apply rst/in, let one rising edge capture them, then check 5 ns after it.
  task automatic step(input string tag, input logic r, input logic [W-1:0] v,
                      input logic [W-1:0] e_b1, input logic [W-1:0] e_b2,
                      input logic [W-1:0] e_n1, input logic [W-1:0] e_n2,
                      input logic e_mm);
    rst = r;
    din = v;
    @(posedge clk);
    #5;
    chk({tag, ".blk_out1"},  blk_out1,  e_b1);
    chk({tag, ".blk_out2"},  blk_out2,  e_b2);
    chk({tag, ".nblk_out1"}, nblk_out1, e_n1);
    chk({tag, ".nblk_out2"}, nblk_out2, e_n2);
`ifdef BLK_NBLK_MISMATCH_EN
    chk1({tag, ".mismatch"}, mismatch, e_mm);
`else
    if (e_mm === 1'bx) chk1({tag, ".unused"}, 1'b0, 1'b1);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    din = 4'hF;

    // Reset held two edges with in=F
    step("rst0", 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step("rst1", 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // Sequence 1,2,3,4,0
    step("seq1", 1'b0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1);
    step("seq2", 1'b0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h1, 1'b1);
    step("seq3", 1'b0, 4'h3, 4'h3, 4'h3, 4'h3, 4'h2, 1'b1);
    step("seq4", 1'b0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h3, 1'b1);
    step("seq0", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 1'b1);

    // in=2 then hold 9 for three edges
    step("hold2",  1'b0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 1'b1);
    step("hold9a", 1'b0, 4'h9, 4'h9, 4'h9, 4'h9, 4'h2, 1'b1);
    step("hold9b", 1'b0, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 1'b0);
    step("hold9c", 1'b0, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 1'b0);

    // Mid-stream reset
    step("mid3",   1'b0, 4'h3, 4'h3, 4'h3, 4'h3, 4'h9, 1'b1);
    step("mid4",   1'b0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h3, 1'b1);
    step("midrst", 1'b1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step("mid5a",  1'b0, 4'h5, 4'h5, 4'h5, 4'h5, 4'h0, 1'b1);
    step("mid5b",  1'b0, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 1'b0);

    // Full-scale and zero words keep their width end to end
    step("maxF", 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h5, 1'b1);
    step("max0", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1);
    step("alt",  1'b0, 4'hA, 4'hA, 4'hA, 4'hA, 4'h0, 1'b1);

    // Reset then 1,2,2: mismatch high twice, then low
    step("mmrst", 1'b1, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step("mm1",   1'b0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1);
    step("mm2",   1'b0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h1, 1'b1);
    step("mm2h",  1'b0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
